spi_flash_cmd_master: RTL and testbench

//  Single-lane SPI master (mode 0) that runs one flash transaction per command: assert SS,

---
 rtl/spi_flash_cmd_master.sv | 196 +++++++++++++++++++
 tb/tb_spi_flash_cmd_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_cmd_master.sv
// Single-lane mode-0 SPI master: one flash transaction per command
// (opcode, optional 24-bit address, then N response bytes).
// Ports: clk/reset (sync, active-high); io_cmd_* command stream in;
// io_rsp_* response byte stream out; io_busy status; io_spi_* flash pins.
// Macro SPI_FLASH_ADDR_EN: when defined, the address phase is built and
// io_cmd_has_addr is honoured; otherwise io_cmd_has_addr/io_cmd_addr are ignored.
module spi_flash_cmd_master #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_cmd_valid,
  output logic             io_cmd_ready,
  input  logic [7:0]       io_cmd_opcode,
  input  logic             io_cmd_has_addr,
  input  logic [23:0]      io_cmd_addr,
  input  logic [LEN_W-1:0] io_cmd_rsp_len,
  output logic             io_rsp_valid,
  input  logic             io_rsp_ready,
  output logic [7:0]       io_rsp_data,
  output logic             io_busy,
  output logic             io_spi_sclk,
  output logic             io_spi_mosi,
  input  logic             io_spi_miso,
  output logic             io_spi_ss
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  // opcode[7] goes straight to mosi on accept, so the shifter holds the rest
`ifdef SPI_FLASH_ADDR_EN
  localparam int TX_W = 31;
`else
  localparam int TX_W = 7;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_ADR, S_RSP, S_HOLD, S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [TX_W-1:0]  tx_q, tx_d;
  logic [6:0]       rx_q, rx_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             ss_q, ss_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;

  logic   accept, stall, tick, shifting, fall;
  state_t rsp_or_hold, after_cmd;

`ifdef SPI_FLASH_ADDR_EN
  logic has_addr_q, has_addr_d;
`else
  logic unused_addr;
  assign unused_addr = ^{io_cmd_has_addr, io_cmd_addr};
`endif

  assign accept   = (state_q == S_IDLE) && io_cmd_valid && !rsp_valid_q;
  // next byte may not start while the previous one is still unconsumed
  assign stall    = (state_q == S_RSP) && (bit_q == 5'd0) && !sclk_q &&
                    rsp_valid_q && !io_rsp_ready;
  assign tick     = (div_q == DIV_MAX) && !stall;
  assign shifting = (state_q == S_CMD) || (state_q == S_ADR) ||
                    (state_q == S_RSP);
  assign fall     = tick && sclk_q && shifting;

  assign rsp_or_hold = (rem_q != '0) ? S_RSP : S_HOLD;
`ifdef SPI_FLASH_ADDR_EN
  assign after_cmd = has_addr_q ? S_ADR : rsp_or_hold;
`else
  assign after_cmd = rsp_or_hold;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rem_q       <= '0;
      ss_q        <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef SPI_FLASH_ADDR_EN
      has_addr_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rem_q       <= rem_d;
      ss_q        <= ss_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef SPI_FLASH_ADDR_EN
      has_addr_q  <= has_addr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_SETUP;
      S_SETUP: if (tick) state_d = S_CMD;
      S_CMD:   if (fall && bit_q == 5'd7) state_d = after_cmd;
`ifdef SPI_FLASH_ADDR_EN
      S_ADR:   if (fall && bit_q == 5'd23) state_d = rsp_or_hold;
`endif
      S_RSP:   if (fall && bit_q == 5'd7 && rem_q == LEN_W'(1))
                 state_d = S_HOLD;
      S_HOLD:  if (tick) state_d = S_GAP;
      S_GAP:   if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d       = div_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rem_d       = rem_q;
    ss_d        = ss_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef SPI_FLASH_ADDR_EN
    has_addr_d  = has_addr_q;
`endif

    if (state_q == S_IDLE || tick) div_d = '0;
    else if (!stall)               div_d = div_q + 1'b1;

    if (rsp_valid_q && io_rsp_ready) rsp_valid_d = 1'b0;

    if (accept) begin
      ss_d   = 1'b0;
      mosi_d = io_cmd_opcode[7];
      bit_d  = '0;
      rem_d  = io_cmd_rsp_len;
`ifdef SPI_FLASH_ADDR_EN
      tx_d       = {io_cmd_opcode[6:0], io_cmd_addr};
      has_addr_d = io_cmd_has_addr;
`else
      tx_d       = io_cmd_opcode[6:0];
`endif
    end

    if (tick && shifting) sclk_d = ~sclk_q;

    if (fall) begin
      bit_d = bit_q + 5'd1;
      tx_d  = {tx_q[TX_W-2:0], 1'b0};
      // mosi carries data only while the next half-bit is still CMD/ADR
      mosi_d = ((state_d == S_CMD) || (state_d == S_ADR)) ?
               tx_q[TX_W-1] : 1'b0;
      if (state_d != state_q) bit_d = '0;
      if (state_q == S_RSP) begin
        rx_d = {rx_q[5:0], io_spi_miso};
        if (bit_q == 5'd7) begin
          rsp_data_d  = {rx_q, io_spi_miso};
          rsp_valid_d = 1'b1;
          rem_d       = rem_q - 1'b1;
          bit_d       = '0;
        end
      end
    end

    if (state_q == S_HOLD && tick) ss_d = 1'b1;
  end

  assign io_cmd_ready = (state_q == S_IDLE) && !rsp_valid_q;
  assign io_busy      = (state_q != S_IDLE);
  assign io_rsp_valid = rsp_valid_q;
  assign io_rsp_data  = rsp_data_q;
  assign io_spi_sclk  = sclk_q;
  assign io_spi_mosi  = mosi_q;
  assign io_spi_ss    = ss_q;

endmodule

// File: tb/tb_spi_flash_cmd_master.sv
// Testbench for spi_flash_cmd_master: behavioural flash model plus
// randomized command/response traffic against per-transaction expectations.
module tb_spi_flash_cmd_master;
  localparam int CLK_DIV = 2;
  localparam int LEN_W   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             io_cmd_valid;
  logic             io_cmd_ready;
  logic [7:0]       io_cmd_opcode;
  logic             io_cmd_has_addr;
  logic [23:0]      io_cmd_addr;
  logic [LEN_W-1:0] io_cmd_rsp_len;
  logic             io_rsp_valid;
  logic             io_rsp_ready;
  logic [7:0]       io_rsp_data;
  logic             io_busy;
  logic             io_spi_sclk;
  logic             io_spi_mosi;
  logic             io_spi_miso;
  logic             io_spi_ss;

  logic rdy_rand_en, rdy_manual, rnd_bit;

  always #5 clk = ~clk;

  spi_flash_cmd_master #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
    .io_cmd_opcode(io_cmd_opcode), .io_cmd_has_addr(io_cmd_has_addr),
    .io_cmd_addr(io_cmd_addr), .io_cmd_rsp_len(io_cmd_rsp_len),
    .io_rsp_valid(io_rsp_valid), .io_rsp_ready(io_rsp_ready),
    .io_rsp_data(io_rsp_data), .io_busy(io_busy),
    .io_spi_sclk(io_spi_sclk), .io_spi_mosi(io_spi_mosi),
    .io_spi_miso(io_spi_miso), .io_spi_ss(io_spi_ss)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));
  assign io_rsp_ready = rdy_rand_en ? rnd_bit : rdy_manual;

  // flash model: records mosi on rising sclk, drives miso after rising sclk
  int         edges;
  int         cmd_bits;
  logic [7:0] rsp_bytes [16];
  bit         mosi_bits [$];

  always @(negedge io_spi_ss) begin
    edges = 0;
    mosi_bits.delete();
  end

  always @(posedge io_spi_sclk) begin
    int k;
    if (!io_spi_ss) begin
      mosi_bits.push_back(io_spi_mosi);
      edges++;
      if (edges > cmd_bits) begin
        k = edges - cmd_bits - 1;
        io_spi_miso <= rsp_bytes[k >> 3][3'(7 - (k % 8))];
      end
    end
  end

  // response consumer and activity monitor
  logic [7:0] got_q [$];
  bit         valid_seen;
  int         gap_cyc;

  always @(posedge clk) begin
    if (io_rsp_valid && io_rsp_ready) got_q.push_back(io_rsp_data);
    if (io_rsp_valid) valid_seen = 1'b1;
    if (io_spi_ss && io_busy) gap_cyc++;
  end

  task automatic send_cmd(logic [7:0] op, logic h, logic [23:0] adr,
                          logic [LEN_W-1:0] len);
    int cyc = 0;
    while (!io_cmd_ready && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("cmd_ready_wait", 32'(cyc < 1000), 1);
    io_cmd_opcode   = op;
    io_cmd_has_addr = h;
    io_cmd_addr     = adr;
    io_cmd_rsp_len  = len;
    io_cmd_valid    = 1'b1;
    @(negedge clk);
    io_cmd_valid    = 1'b0;
  endtask

  task automatic run_txn(string nm, logic [7:0] op, logic h,
                         logic [23:0] adr, int len, bit bp);
    int eff_h, cyc, ones, e0, hi;
    logic [31:0] hdr, exp_hdr;
`ifdef SPI_FLASH_ADDR_EN
    eff_h = int'(h);
`else
    eff_h = 0;
`endif
    cmd_bits   = 8 + 24 * eff_h;
    got_q.delete();
    valid_seen = 1'b0;
    gap_cyc    = 0;
    send_cmd(op, h, adr, LEN_W'(len));

    if (bp) begin
      cyc = 0;
      while (!io_rsp_valid && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      chk({nm, "_first_byte"}, 32'(cyc < 2000), 1);
      e0 = edges;
      chk({nm, "_edges_at_stall"}, e0, cmd_bits + 8);
      hi = 0;
      repeat (40) begin
        @(negedge clk);
        if (io_spi_sclk) hi++;
      end
      chk({nm, "_frozen"}, edges, e0);
      chk({nm, "_sclk_low"}, hi, 0);
      chk({nm, "_valid_held"}, 32'(io_rsp_valid), 1);
      chk({nm, "_ss_low"}, 32'(io_spi_ss), 0);
      rdy_manual = 1'b1;
    end

    cyc = 0;
    while ((io_busy || got_q.size() < len) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_done"}, 32'(cyc < 20000), 1);

    chk({nm, "_edges"}, edges, 8 + 24 * eff_h + 8 * len);
    hdr = '0;
    for (int i = 0; i < cmd_bits && i < mosi_bits.size(); i++)
      hdr = {hdr[30:0], mosi_bits[i]};
    exp_hdr = (eff_h != 0) ? {op, adr} : {24'd0, op};
    chk({nm, "_mosi_hdr"}, hdr, exp_hdr);
    ones = 0;
    for (int i = cmd_bits; i < mosi_bits.size(); i++)
      if (mosi_bits[i]) ones++;
    chk({nm, "_mosi_rsp_zero"}, ones, 0);
    chk({nm, "_nbytes"}, got_q.size(), len);
    for (int i = 0; i < len && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), 32'(got_q[i]), 32'(rsp_bytes[i]));
    chk({nm, "_valid_seen"}, 32'(valid_seen), 32'(len != 0));
    chk({nm, "_gap"}, gap_cyc, CLK_DIV);
    chk({nm, "_ss_idle"}, 32'(io_spi_ss), 1);
    chk({nm, "_sclk_idle"}, 32'(io_spi_sclk), 0);
    chk({nm, "_cmd_ready"}, 32'(io_cmd_ready), 1);
  endtask

  initial begin
    int cyc;
    int len;
    reset           = 1'b1;
    io_cmd_valid    = 1'b0;
    io_cmd_opcode   = '0;
    io_cmd_has_addr = 1'b0;
    io_cmd_addr     = '0;
    io_cmd_rsp_len  = '0;
    io_spi_miso     = 1'b0;
    rdy_rand_en     = 1'b0;
    rdy_manual      = 1'b1;
    cmd_bits        = 8;
    edges           = 0;
    for (int i = 0; i < 16; i++) rsp_bytes[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_ss", 32'(io_spi_ss), 1);
    chk("rst_sclk", 32'(io_spi_sclk), 0);
    chk("rst_mosi", 32'(io_spi_mosi), 0);
    chk("rst_cmd_ready", 32'(io_cmd_ready), 1);
    chk("rst_rsp_valid", 32'(io_rsp_valid), 0);
    chk("rst_rsp_data", 32'(io_rsp_data), 0);
    chk("rst_busy", 32'(io_busy), 0);
    reset = 1'b0;
    @(negedge clk);

    rsp_bytes[0] = 8'h20;
    run_txn("rdid", 8'h9E, 1'b0, 24'h0, 1, 1'b0);

    rsp_bytes[0] = 8'($urandom);
    rsp_bytes[1] = 8'($urandom);
    run_txn("read", 8'h03, 1'b1, 24'h123456, 2, 1'b0);

    for (int i = 0; i < 3; i++) rsp_bytes[i] = 8'($urandom);
    rdy_manual = 1'b0;
    run_txn("bp", 8'h0B, 1'b0, 24'h0, 3, 1'b1);

    run_txn("len0", 8'h06, 1'b0, 24'h0, 0, 1'b0);

    // abort a transaction part way through its second phase
    for (int i = 0; i < 2; i++) rsp_bytes[i] = 8'($urandom);
    cmd_bits = 32;
`ifndef SPI_FLASH_ADDR_EN
    cmd_bits = 8;
`endif
    send_cmd(8'h03, 1'b1, 24'($urandom), LEN_W'(2));
    cyc = 0;
    while (edges < 12 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reach", 32'(cyc < 500), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ss", 32'(io_spi_ss), 1);
    chk("abort_sclk", 32'(io_spi_sclk), 0);
    chk("abort_busy", 32'(io_busy), 0);
    chk("abort_rsp_valid", 32'(io_rsp_valid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) rsp_bytes[i] = 8'($urandom);
    run_txn("post_abort", 8'h0B, 1'b1, 24'hABCDEF, 2, 1'b0);

    rdy_rand_en = 1'b1;
    for (int t = 0; t < 10; t++) begin
      len = (t == 0) ? 15 : int'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) rsp_bytes[i] = 8'($urandom);
      run_txn($sformatf("rnd%0d", t), 8'($urandom),
              1'($urandom_range(0, 1)), 24'($urandom), len, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
